// File: rtl/mixer_scheduler_if.sv
// Channel-side, mixer-side and tagged-output signals of the mixer scheduler.
// master = environment side, slave = scheduler side.
interface mixer_scheduler_if #(
    parameter int DW  = 16,
    parameter int NCH = 4,
    parameter int CW  = $clog2(NCH)
);
    logic [NCH-1:0]    en_i;
    logic [NCH-1:0]    ch_valid_i;
    logic [NCH*DW-1:0] ch_data_i;
    logic [NCH-1:0]    ch_ready_o;
    logic [DW-1:0]     mix_data_o;
    logic              mix_valid_o;
    logic [DW-1:0]     mix_data_i;
    logic              mix_valid_i;
    logic              mix_last_i;
    logic [DW-1:0]     data_o;
    logic [CW-1:0]     chan_o;
    logic              part_o;
    logic              valid_o;
    logic              err_o;

    modport master (
        output en_i, ch_valid_i, ch_data_i, mix_data_i, mix_valid_i, mix_last_i,
        input  ch_ready_o, mix_data_o, mix_valid_o, data_o, chan_o, part_o, valid_o, err_o
    );

    modport slave (
        input  en_i, ch_valid_i, ch_data_i, mix_data_i, mix_valid_i, mix_last_i,
        output ch_ready_o, mix_data_o, mix_valid_o, data_o, chan_o, part_o, valid_o, err_o
    );
endinterface

// File: rtl/mixer_scheduler.sv
// Round-robin feeder for one shared sin/cos mixer; issue at T -> sin out T+4, cos out T+5.
// Issues at most every 3 cycles; channels see a one-hot ready strobe only on issue.
module mixer_scheduler #(
    parameter int DW  = 16,
    parameter int NCH = 4,
    parameter int CW  = $clog2(NCH)
) (
    input logic clk,
    input logic rst,
    mixer_scheduler_if.slave bus
);

    logic [NCH-1:0] req;
    logic [CW-1:0]  last_grant;
    logic [CW-1:0]  grant;
    logic           grant_found;
    logic [1:0]     gap;
    logic           issue;
    logic [NCH-1:0] ready_vec;

    assign req = bus.ch_valid_i & bus.en_i;

    always_comb begin
        int unsigned idx;
        idx         = 0;
        grant       = '0;
        grant_found = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            idx = (int'(last_grant) + 1 + i) % NCH;
            if (!grant_found && req[idx]) begin
                grant       = CW'(idx);
                grant_found = 1'b1;
            end
        end
    end

    // rst gates the strobe so ready drops the moment reset is applied
    assign issue = (gap == 2'd0) && (req != '0) && !rst;

    always_comb begin
        ready_vec = '0;
        if (issue) ready_vec[grant] = 1'b1;
    end
    assign bus.ch_ready_o = ready_vec;

    // Two-entry tag FIFO: one tag waits on its cos product while the next issue lands
    logic [CW-1:0] tag_mem [2];
    logic          wr_ptr, rd_ptr;
    logic [1:0]    count;
    logic          fifo_empty, fifo_full, pop, push_ok, err_set;
    logic [CW-1:0] head;

    assign fifo_empty = (count == 2'd0);
    assign fifo_full  = (count == 2'd2);
    assign pop        = bus.mix_valid_i && bus.mix_last_i && !fifo_empty;
    assign push_ok    = issue && (!fifo_full || pop);
    assign head       = fifo_empty ? '0 : tag_mem[rd_ptr];
    assign err_set    = (bus.mix_valid_i && fifo_empty) || (issue && fifo_full && !pop);

    logic [DW-1:0] mix_data_r;
    logic          mix_valid_r;
    logic [DW-1:0] data_r;
    logic [CW-1:0] chan_r;
    logic          part_r, valid_r, err_r;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant  <= CW'(NCH - 1);
            gap         <= 2'd0;
            tag_mem[0]  <= '0;
            tag_mem[1]  <= '0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            count       <= 2'd0;
            mix_data_r  <= '0;
            mix_valid_r <= 1'b0;
            data_r      <= '0;
            chan_r      <= '0;
            part_r      <= 1'b0;
            valid_r     <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            mix_valid_r <= issue;
            if (issue) begin
                last_grant <= grant;
                mix_data_r <= bus.ch_data_i[grant*DW +: DW];
                gap        <= 2'd2;
            end else if (gap != 2'd0) begin
                gap <= gap - 2'd1;
            end

            if (push_ok) begin
                tag_mem[wr_ptr] <= grant;
                wr_ptr          <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            case ({push_ok, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase

            valid_r <= bus.mix_valid_i;
            if (bus.mix_valid_i) begin
                data_r <= bus.mix_data_i;
                chan_r <= head;
                part_r <= bus.mix_last_i;
            end

            if (err_set) err_r <= 1'b1;
        end
    end

    assign bus.mix_data_o  = mix_data_r;
    assign bus.mix_valid_o = mix_valid_r;
    assign bus.data_o      = data_r;
    assign bus.chan_o      = chan_r;
    assign bus.part_o      = part_r;
    assign bus.valid_o     = valid_r;
    assign bus.err_o       = err_r;

endmodule

// File: tb/tb_mixer_scheduler.sv
// Directed bench for mixer_scheduler with a behavioural two-cycle sin/cos mixer.
module tb_mixer_scheduler;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    mixer_scheduler_if #(.DW(16), .NCH(4)) bus ();

    mixer_scheduler #(.DW(16), .NCH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Mixer model: sample seen in T+1, sin product in T+3, cos product in T+4
    logic        p1, p2, p3;
    logic [15:0] smp;
    logic        mute, inject;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            p1  <= 1'b0;
            p2  <= 1'b0;
            p3  <= 1'b0;
            smp <= '0;
        end else begin
            p1 <= bus.mix_valid_o;
            p2 <= p1;
            p3 <= p2;
            if (bus.mix_valid_o) smp <= bus.mix_data_o;
        end
    end

    assign bus.mix_valid_i = inject | (!mute & (p2 | p3));
    assign bus.mix_last_i  = !inject & !mute & p3;
    assign bus.mix_data_i  = inject ? 16'h7777 :
                             p3     ? 16'($signed(smp) >>> 2) : 16'($signed(smp) >>> 1);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_vec++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.en_i       = '0;
        bus.ch_valid_i = '0;
        inject         = 1'b0;
        mute           = 1'b0;
        rst            = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    typedef struct {
        logic [3:0]  en;
        logic [3:0]  vld;
        logic [3:0]  g1;
        logic        mv;
        logic [15:0] md;
        logic [3:0]  g2;
    } vec_t;

    vec_t vt [10];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [3:0]  er;
        logic [15:0] d, ed;
        int          k, ph;
        logic        ev;

        n_vec = 0;
        n_err = 0;
        vt[0] = '{4'hF, 4'hF, 4'b0001, 1'b1, 16'h0400, 4'b0010};
        vt[1] = '{4'hF, 4'h4, 4'b0100, 1'b1, 16'h0C00, 4'b0100};
        vt[2] = '{4'hD, 4'h2, 4'b0000, 1'b0, 16'h0000, 4'b0000};
        vt[3] = '{4'hF, 4'h8, 4'b1000, 1'b1, 16'h1000, 4'b1000};
        vt[4] = '{4'h6, 4'hF, 4'b0010, 1'b1, 16'h0800, 4'b0100};
        vt[5] = '{4'hF, 4'h9, 4'b0001, 1'b1, 16'h0400, 4'b1000};
        vt[6] = '{4'hF, 4'h0, 4'b0000, 1'b0, 16'h0000, 4'b0000};
        vt[7] = '{4'h0, 4'hF, 4'b0000, 1'b0, 16'h0000, 4'b0000};
        vt[8] = '{4'hA, 4'hF, 4'b0010, 1'b1, 16'h0800, 4'b1000};
        vt[9] = '{4'hF, 4'h3, 4'b0001, 1'b1, 16'h0400, 4'b0010};

        bus.ch_data_i = {16'h1000, 16'h0C00, 16'h0800, 16'h0400};
        bus.en_i       = '0;
        bus.ch_valid_i = '0;
        inject         = 1'b0;
        mute           = 1'b0;
        rst            = 1'b1;
        #3;
        chk("reset_ready",     32'(bus.ch_ready_o),  32'h0);
        chk("reset_mix_valid", 32'(bus.mix_valid_o), 32'h0);
        chk("reset_valid",     32'(bus.valid_o),     32'h0);
        chk("reset_err",       32'(bus.err_o),       32'h0);

        // Table: fresh reset, first grant, issued sample, grant three cycles later
        for (int v = 0; v < 10; v++) begin
            do_reset();
            bus.en_i       = vt[v].en;
            bus.ch_valid_i = vt[v].vld;
            #1;
            chk($sformatf("vec%0d_grant1", v), 32'(bus.ch_ready_o), 32'(vt[v].g1));
            tick();
            chk($sformatf("vec%0d_mix_valid", v), 32'(bus.mix_valid_o), 32'(vt[v].mv));
            chk($sformatf("vec%0d_mix_data", v),  32'(bus.mix_data_o),  32'(vt[v].md));
            chk($sformatf("vec%0d_gap_ready", v), 32'(bus.ch_ready_o),  32'h0);
            tick();
            tick();
            chk($sformatf("vec%0d_grant2", v), 32'(bus.ch_ready_o), 32'(vt[v].g2));
        end

        // All channels requesting: grants 0,1,2,3,0 and tagged sin/cos pairs in order
        do_reset();
        bus.en_i       = 4'hF;
        bus.ch_valid_i = 4'hF;
        for (int c = 0; c < 18; c++) begin
            if (c == 0) #1;
            else tick();
            er = (c % 3 == 0) ? 4'(1 << ((c / 3) % 4)) : 4'd0;
            chk($sformatf("rr_ready_c%0d", c), 32'(bus.ch_ready_o), 32'(er));
            ev = (c >= 4) && ((c - 4) % 3 < 2);
            chk($sformatf("rr_valid_c%0d", c), 32'(bus.valid_o), 32'(ev));
            if (ev) begin
                k  = (c - 4) / 3;
                ph = (c - 4) % 3;
                d  = 16'(16'h0400 * (k % 4 + 1));
                ed = (ph == 1) ? (d >> 2) : (d >> 1);
                chk($sformatf("rr_chan_c%0d", c), 32'(bus.chan_o), 32'(k % 4));
                chk($sformatf("rr_part_c%0d", c), 32'(bus.part_o), 32'(ph));
                chk($sformatf("rr_data_c%0d", c), 32'(bus.data_o), 32'(ed));
            end
        end
        chk("rr_err", 32'(bus.err_o), 32'h0);

        // Channel 2 alone: issue every 3 cycles, valid_o 1,1,0 from T+4
        do_reset();
        bus.en_i       = 4'hF;
        bus.ch_valid_i = 4'b0100;
        for (int c = 0; c < 14; c++) begin
            if (c == 0) #1;
            else tick();
            er = (c % 3 == 0) ? 4'b0100 : 4'd0;
            chk($sformatf("ch2_ready_c%0d", c), 32'(bus.ch_ready_o), 32'(er));
            ev = (c >= 4) && ((c - 4) % 3 != 2);
            chk($sformatf("ch2_valid_c%0d", c), 32'(bus.valid_o), 32'(ev));
            if (ev) chk($sformatf("ch2_chan_c%0d", c), 32'(bus.chan_o), 32'h2);
        end

        // Disabled channel never served
        do_reset();
        bus.en_i       = 4'b1101;
        bus.ch_valid_i = 4'b0010;
        for (int c = 0; c < 10; c++) begin
            if (c == 0) #1;
            else tick();
            chk($sformatf("dis_ready_c%0d", c),     32'(bus.ch_ready_o),  32'h0);
            chk($sformatf("dis_mix_valid_c%0d", c), 32'(bus.mix_valid_o), 32'h0);
        end

        // Single sample 0x4000 through the mixer: 0x2000 at T+4, 0x1000 at T+5
        do_reset();
        bus.ch_data_i[15:0] = 16'h4000;
        bus.en_i            = 4'hF;
        bus.ch_valid_i      = 4'b0001;
        #1;
        chk("one_ready", 32'(bus.ch_ready_o), 32'h1);
        for (int c = 1; c < 8; c++) begin
            tick();
            if (c == 1) bus.ch_valid_i = '0;
            chk($sformatf("one_valid_c%0d", c), 32'(bus.valid_o), 32'((c == 4) || (c == 5)));
            if (c == 4) begin
                chk("one_sin_data", 32'(bus.data_o), 32'h2000);
                chk("one_sin_part", 32'(bus.part_o), 32'h0);
                chk("one_sin_chan", 32'(bus.chan_o), 32'h0);
            end
            if (c == 5) begin
                chk("one_cos_data", 32'(bus.data_o), 32'h1000);
                chk("one_cos_part", 32'(bus.part_o), 32'h1);
                chk("one_cos_chan", 32'(bus.chan_o), 32'h0);
            end
        end
        bus.ch_data_i[15:0] = 16'h0400;

        // Unexpected product: err_o next cycle, sticky until reset
        do_reset();
        inject = 1'b1;
        #1;
        chk("inj_err_same_cycle", 32'(bus.err_o), 32'h0);
        tick();
        inject = 1'b0;
        chk("inj_err",   32'(bus.err_o),   32'h1);
        chk("inj_valid", 32'(bus.valid_o), 32'h1);
        chk("inj_chan",  32'(bus.chan_o),  32'h0);
        chk("inj_data",  32'(bus.data_o),  32'h7777);
        repeat (5) tick();
        chk("inj_err_sticky", 32'(bus.err_o), 32'h1);
        rst = 1'b1;
        #1;
        chk("inj_err_cleared", 32'(bus.err_o), 32'h0);
        tick();
        rst = 1'b0;

        // Reset mid-flight, asserted between clock edges
        bus.en_i       = 4'hF;
        bus.ch_valid_i = 4'hF;
        #1;
        chk("mid_grant0", 32'(bus.ch_ready_o), 32'h1);
        repeat (3) tick();
        chk("mid_grant1", 32'(bus.ch_ready_o), 32'h2);
        repeat (2) tick();
        chk("mid_pre_valid", 32'(bus.valid_o), 32'h1);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_ready",     32'(bus.ch_ready_o),  32'h0);
        chk("mid_mix_valid", 32'(bus.mix_valid_o), 32'h0);
        chk("mid_mix_data",  32'(bus.mix_data_o),  32'h0);
        chk("mid_valid",     32'(bus.valid_o),     32'h0);
        chk("mid_data",      32'(bus.data_o),      32'h0);
        chk("mid_chan",      32'(bus.chan_o),      32'h0);
        chk("mid_part",      32'(bus.part_o),      32'h0);
        chk("mid_err",       32'(bus.err_o),       32'h0);
        tick();
        rst = 1'b0;
        #1;
        chk("post_rst_grant", 32'(bus.ch_ready_o), 32'h1);
        repeat (8) tick();
        chk("post_rst_err", 32'(bus.err_o), 32'h0);

        // No pops: third push into a full tag FIFO is dropped and flags err_o
        do_reset();
        mute           = 1'b1;
        bus.en_i       = 4'hF;
        bus.ch_valid_i = 4'b0001;
        for (int c = 0; c < 9; c++) begin
            if (c == 0) #1;
            else tick();
            if (c == 4) chk("full_err_c4", 32'(bus.err_o), 32'h0);
            if (c == 6) chk("full_err_c6", 32'(bus.err_o), 32'h0);
            if (c == 7) chk("full_err_c7", 32'(bus.err_o), 32'h1);
        end
        do_reset();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
